// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline control path: sequencer states,
// default counter width and the per-stage control bundle.
package arm_pipe_pkg;

   localparam int DEFAULT_CNT_W = 32;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MEM_WAIT  = 2'd1,
      MEM_ABORT = 2'd2
   } state_t;

   typedef struct packed {
      logic freeze_pc_if_id;
      logic bubble_id_exe;
      logic flush_if_id;
      logic flush_id_exe;
      logic freeze_all;
   } stage_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard/branch/memory request inputs and the merged stage controls.
// master is the pipeline side, slave is the hazard controller.
interface pipeline_hazard_controller_if #(
   parameter int CNT_W = 32
);
   logic             hazard;
   logic             branch_taken;
   logic             mem_req;
   logic             sram_ready;
   logic             cnt_clr;
   logic             freeze_pc_if_id;
   logic             bubble_id_exe;
   logic             flush_if_id;
   logic             flush_id_exe;
   logic             freeze_all;
   logic             sram_start;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] memwait_cnt;

   modport master (
      output hazard, branch_taken, mem_req, sram_ready, cnt_clr,
      input  freeze_pc_if_id, bubble_id_exe, flush_if_id, flush_id_exe,
             freeze_all, sram_start, mem_error, stall_cnt, flush_cnt, memwait_cnt
   );

   modport slave (
      input  hazard, branch_taken, mem_req, sram_ready, cnt_clr,
      output freeze_pc_if_id, bubble_id_exe, flush_if_id, flush_id_exe,
             freeze_all, sram_start, mem_error, stall_cnt, flush_cnt, memwait_cnt
   );
endinterface

// File: rtl/perf_counter_sat.sv
// Saturating performance counter: holds at all-ones, clear beats increment.
module perf_counter_sat #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer: merges load-use hazard, taken branch and
// multi-cycle SRAM access into one set of stage controls, with perf counters.
module pipeline_hazard_controller
   import arm_pipe_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input logic                          clk,
   input logic                          rst_n,
   pipeline_hazard_controller_if.slave  bus
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_wait_ctr;
   logic        r_mem_error;
   logic        w_freeze;
   logic        w_start;
   stage_ctrl_t w_ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_freeze     = 1'b0;
      w_start      = 1'b0;
      case (r_state)
         RUN: begin
            if (bus.mem_req) begin
               w_start      = 1'b1;
               w_freeze     = 1'b1;
               w_next_state = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (bus.sram_ready) begin
               w_next_state = RUN;
            end else begin
               w_freeze = 1'b1;
               if (r_wait_ctr == WAIT_LAST) begin
                  w_next_state = MEM_ABORT;
               end
            end
         end
         MEM_ABORT: w_next_state = RUN;
         default:   w_next_state = RUN;
      endcase
   end

   // wait_ctr counts unanswered MEM_WAIT cycles; mem_error is sticky once an abort happens
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_ctr  <= '0;
         r_mem_error <= 1'b0;
      end else begin
         if (r_state == RUN) begin
            r_wait_ctr <= '0;
         end else if ((r_state == MEM_WAIT) && !bus.sram_ready) begin
            r_wait_ctr <= r_wait_ctr + 16'd1;
         end
         if (r_state == MEM_ABORT) begin
            r_mem_error <= 1'b1;
         end
      end
   end

   // Freeze masks everything; a taken branch overrides the hazard since ID is wrong-path
   always_comb begin
      w_ctrl.freeze_all      = w_freeze & rst_n;
      w_ctrl.flush_if_id     = bus.branch_taken & ~w_freeze & rst_n;
      w_ctrl.flush_id_exe    = bus.branch_taken & ~w_freeze & rst_n;
      w_ctrl.freeze_pc_if_id = bus.hazard & ~bus.branch_taken & ~w_freeze & rst_n;
      w_ctrl.bubble_id_exe   = bus.hazard & ~bus.branch_taken & ~w_freeze & rst_n;
   end

   assign bus.freeze_pc_if_id = w_ctrl.freeze_pc_if_id;
   assign bus.bubble_id_exe   = w_ctrl.bubble_id_exe;
   assign bus.flush_if_id     = w_ctrl.flush_if_id;
   assign bus.flush_id_exe    = w_ctrl.flush_id_exe;
   assign bus.freeze_all      = w_ctrl.freeze_all;
   assign bus.sram_start      = w_start & rst_n;
   assign bus.mem_error       = r_mem_error;

   perf_counter_sat #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (bus.cnt_clr),
      .i_inc   (w_ctrl.bubble_id_exe),
      .o_count (bus.stall_cnt)
   );

   perf_counter_sat #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (bus.cnt_clr),
      .i_inc   (w_ctrl.flush_if_id),
      .o_count (bus.flush_cnt)
   );

   perf_counter_sat #(.W(CNT_W)) u_memwait_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (bus.cnt_clr),
      .i_inc   (w_ctrl.freeze_all),
      .o_count (bus.memwait_cnt)
   );

endmodule
